// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two write ports (port 1 wins),
// and a per-register pending-write scoreboard. Define REGFILE_MP_BYPASS_EN for same-cycle forwarding.
module regfile_mp #(
  parameter int  XLEN = 32,
  parameter int  NREG = 32,
  parameter int  NRD  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NRD*AW-1:0] i_rs_addr,
  output logic [NRD*XLEN-1:0] o_rs_data,
  output logic [NRD-1:0]    o_rs_busy,
  input  logic              i_wr0_en,
  input  logic [AW-1:0]     i_wr0_addr,
  input  logic [XLEN-1:0]   i_wr0_data,
  input  logic              i_wr1_en,
  input  logic [AW-1:0]     i_wr1_addr,
  input  logic [XLEN-1:0]   i_wr1_data,
  input  logic              i_iss_vld,
  input  logic [AW-1:0]     i_iss_rd,
  output logic              o_busy_any
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            wr0_ok;
  logic            wr1_ok;

  // x0 is never written or marked, so it stays zero and idle
  assign wr0_ok = i_wr0_en && (i_wr0_addr != '0);
  assign wr1_ok = i_wr1_en && (i_wr1_addr != '0);

  // A fresh issue overrides a same-cycle write-back: the new producer is still pending
  always_comb begin
    busy_nxt = busy;
    if (wr0_ok) busy_nxt[i_wr0_addr] = 1'b0;
    if (wr1_ok) busy_nxt[i_wr1_addr] = 1'b0;
    if (i_iss_vld && (i_iss_rd != '0)) busy_nxt[i_iss_rd] = 1'b1;
  end

  // Port 1 is written last so it wins on an address collision
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      if (wr0_ok) regs[i_wr0_addr] <= i_wr0_data;
      if (wr1_ok) regs[i_wr1_addr] <= i_wr1_data;
      busy <= busy_nxt;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            bsy;

    assign addr = i_rs_addr[k*AW +: AW];

    always_comb begin
      data = (addr == '0) ? '0 : regs[addr];
      bsy  = busy[addr];
`ifdef REGFILE_MP_BYPASS_EN
      if (wr1_ok && (i_wr1_addr == addr)) begin
        data = i_wr1_data;
        bsy  = 1'b0;
      end else if (wr0_ok && (i_wr0_addr == addr)) begin
        data = i_wr0_data;
        bsy  = 1'b0;
      end
`endif
    end

    assign o_rs_data[k*XLEN +: XLEN] = data;
    assign o_rs_busy[k]              = bsy;
  end

  assign o_busy_any = |busy;

endmodule
